// File: rtl/lsu_ctrl.sv
// lsu_ctrl: memory-stage load/store unit.
// Takes the decoder's MemWrite/AccessMode/DataExtendMode plus the ALU address
// and store data, drives a req/gnt/rvalid data-memory port and returns
// extracted, sign/zero-extended load data. stall holds the pipeline until the
// one-cycle done pulse.
// Optional macro LSU_TIMEOUT_EN: abort an access that waits TIMEOUT_CYCLES
// cycles in REQ or WAIT_R, reporting bus_err. Without it bus_err is tied to 0.
module lsu_ctrl #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            MemWrite,
    input  logic [1:0]      AccessMode,
    input  logic            DataExtendMode,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] ReadData,
    output logic            misaligned,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT_R = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] AM_BYTE = 2'b00;
    localparam logic [1:0] AM_HALF = 2'b01;
    localparam logic [1:0] AM_WORD = 2'b10;

    // Only a 32-bit datapath and a 16-bit timeout counter are implemented.
    if (XLEN != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
        $error("lsu_ctrl: unsupported XLEN or TIMEOUT_CYCLES");
    end

    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] off);
        case (mode)
            AM_BYTE: is_misaligned = 1'b0;
            AM_HALF: is_misaligned = off[0];
            AM_WORD: is_misaligned = |off;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] mode, input logic [1:0] off);
        case (mode)
            AM_BYTE: calc_be = 4'b0001 << off;
            AM_HALF: calc_be = 4'b0011 << {off[1], 1'b0};
            AM_WORD: calc_be = 4'b1111;
            default: calc_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] mode, input logic [31:0] d);
        case (mode)
            AM_BYTE: replicate = {4{d[7:0]}};
            AM_HALF: replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] mode,
                                                 input logic [1:0] off, input logic sext);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        case (off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (mode)
            AM_BYTE: extract_load = {{24{sext & lane_b[7]}}, lane_b};
            AM_HALF: extract_load = {{16{sext & lane_h[15]}}, lane_h};
            AM_WORD: extract_load = word;
            default: extract_load = 32'h0000_0000;
        endcase
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      next_state_s;
    logic            misalign_s;
    logic            abort_s;
    logic            timeout_s;
    logic            done_r;
    logic            misaligned_r;
    logic            rd_zero_r;
    logic            mem_req_r;
    logic            we_r;
    logic [1:0]      mode_r;
    logic            sext_r;
    logic [1:0]      off_r;
    logic [XLEN-1:0] mem_addr_r;
    logic [3:0]      mem_be_r;
    logic [XLEN-1:0] mem_wdata_r;
    logic [XLEN-1:0] read_data_r;

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_r;
    logic        bus_err_r;

    assign timeout_s = (to_cnt_r == TO_LAST);

    // Wait counter: restarts on entry to REQ or WAIT_R, counts while waiting there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= 16'd0;
        end else if ((next_state_s != state_r) &&
                     ((next_state_s == ST_REQ) || (next_state_s == ST_WAIT_R))) begin
            to_cnt_r <= 16'd0;
        end else if ((state_r == ST_REQ) || (state_r == ST_WAIT_R)) begin
            to_cnt_r <= to_cnt_r + 16'd1;
        end
    end

    // Timeout fault flag, present only during the done cycle of an aborted access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= abort_s;
        end
    end

    assign bus_err = bus_err_r;
`else
    assign timeout_s = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Next-state decode and the abort flag for a timed-out access
    always_comb begin
        next_state_s = state_r;
        abort_s      = 1'b0;
        misalign_s   = is_misaligned(AccessMode, addr[1:0]);
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = misalign_s ? ST_DONE : ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    next_state_s = we_r ? ST_DONE : ST_WAIT_R;
                end else if (timeout_s) begin
                    next_state_s = ST_DONE;
                    abort_s      = 1'b1;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid) begin
                    next_state_s = ST_DONE;
                end else if (timeout_s) begin
                    next_state_s = ST_DONE;
                    abort_s      = 1'b1;
                end else begin
                    next_state_s = ST_WAIT_R;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register, memory request and one-cycle completion status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            done_r       <= 1'b0;
            mem_req_r    <= 1'b0;
            misaligned_r <= 1'b0;
            rd_zero_r    <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            done_r       <= (next_state_s == ST_DONE);
            mem_req_r    <= (next_state_s == ST_REQ);
            misaligned_r <= (state_r == ST_IDLE) & req_valid & misalign_s;
            // A faulting load shows zero only in its done cycle.
            rd_zero_r    <= ((state_r == ST_IDLE) & req_valid & misalign_s & ~MemWrite) |
                            (abort_s & ~we_r);
        end
    end

    // Capture the access attributes and bus fields when a request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r        <= 1'b0;
            mode_r      <= 2'b00;
            sext_r      <= 1'b0;
            off_r       <= 2'b00;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= '0;
        end else if ((state_r == ST_IDLE) && req_valid) begin
            we_r        <= MemWrite;
            mode_r      <= AccessMode;
            sext_r      <= DataExtendMode;
            off_r       <= addr[1:0];
            mem_addr_r  <= {addr[XLEN-1:2], 2'b00};
            mem_be_r    <= calc_be(AccessMode, addr[1:0]);
            mem_wdata_r <= replicate(AccessMode, wdata);
        end
    end

    // Load result register: updated only by a completed load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_r <= '0;
        end else if ((state_r == ST_WAIT_R) && mem_rvalid) begin
            read_data_r <= extract_load(mem_rdata, mode_r, off_r, sext_r);
        end
    end

    assign stall      = req_valid & ~done_r;
    assign done       = done_r;
    assign misaligned = misaligned_r;
    assign ReadData   = rd_zero_r ? '0 : read_data_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_be     = mem_be_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly downstream of the main decoder, in the memory stage.
- Consumes the decoder's MemWrite, AccessMode and DataExtendMode together with the ALU-computed address and store data.
- Drives a req/gnt/rvalid data-memory port, generating byte enables and lane-replicated write data.
- Returns size-extracted, sign- or zero-extended load data, stalling the pipeline until the access completes.

Parameters:
- XLEN, 32: data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ or WAIT_R before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  memory-stage instruction is a load or store
- MemWrite  in  1  1 = store, 0 = load
- AccessMode  in  2  00 byte, 01 half, 10 word, 11 illegal
- DataExtendMode  in  1  1 = sign-extend load, 0 = zero-extend
- addr  in  XLEN  byte address
- wdata  in  XLEN  store data (low bits significant)
- stall  out  1  hold pipeline
- done  out  1  one-cycle completion pulse
- ReadData  out  XLEN  extended load result
- misaligned  out  1  alignment/illegal-size fault, valid with done
- bus_err  out  1  timeout fault, valid with done
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  XLEN  word address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read word

Behaviour:
- Reset: one clock; reset asynchronous, active-low. All outputs are 0 and the state is IDLE; ReadData = 0. Reset mid-access returns immediately to IDLE and drops mem_req without waiting for gnt/rvalid.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - On req_valid, latch MemWrite, AccessMode, DataExtendMode, addr[1:0], mem_addr, mem_be, mem_wdata.
  - Alignment check: half needs addr[0]=0, word needs addr[1:0]=00, AccessMode 11 always faults.
  - On fault, go to DONE with misaligned=1; no mem_req is ever issued.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_be, mem_wdata are held stable until mem_gnt.
  - On gnt, a store goes to DONE and a load goes to WAIT_R.
- WAIT_R:
  - mem_req=0. mem_rvalid is never expected in the gnt cycle.
  - On mem_rvalid, register the extracted load data into ReadData and go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. misaligned and bus_err are valid only while done=1 and are otherwise 0.
- stall = req_valid & ~done (combinational). The pipeline advances in the done cycle; a new request is accepted only in IDLE. Minimum latency is therefore 3 cycles for a store and 4 for a load with zero-wait memory.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction:
  - Select the lane from mem_rdata by the latched addr[1:0].
  - Byte uses bit 7 and half uses bit 15 as the sign bit when DataExtendMode=1; otherwise zero-fill.
- ReadData:
  - Holds its value until the next successful load; stores and faults do not change it.
  - A faulting load drives ReadData = 0 during the done cycle only.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8..16-bit counter is cleared on entry to REQ and on entry to WAIT_R, and increments every cycle spent in either state.
  - On reaching TIMEOUT_CYCLES, go to DONE with bus_err=1 and drop mem_req. For a load, ReadData is 0 during that done cycle and the previous value is restored afterwards.
  - A late mem_rvalid arriving in IDLE is ignored.
- LSU_TIMEOUT_EN undefined: no counter; bus_err is tied to 0 and the unit waits indefinitely.

Test Plan:
- lb, addr=0x1003, mem_rdata=0x80FF_0000, DataExtendMode=1 -> mem_addr=0x1000, mem_be=1000, ReadData=0xFFFF_FF80, done 4 cycles after accept with zero-wait memory.
- lhu, addr=0x2002, mem_rdata=0xBEEF_1234 -> mem_be=1100, ReadData=0x0000_BEEF.
- sb, addr=0x3001, wdata=0x1234_56AB -> mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB; gnt delayed 3 cycles -> request fields stable throughout, stall held high until done.
- lw, addr=0x4002 -> no mem_req, done with misaligned=1 in cycle 2; AccessMode=11 gives the same result.
- sw followed by lw back-to-back -> second request accepted only after DONE→IDLE; ReadData unchanged by the sw.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mem_gnt never asserted -> bus_err=1 with done after 8 REQ cycles, mem_req then 0; rst_n low mid-REQ -> mem_req=0 immediately.
